// File: rtl/auth_pkg.sv
// Shared types and default constants for the power-up authenticator.
package auth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MATCH,
    ON,
    STOPPING,
    LOCK
  } state_t;

  localparam logic [15:0] DEF_ON_KEY    = 16'h4753;
  localparam logic [7:0]  DEF_STOP_BYTE = 8'h53;

endpackage

// File: rtl/auth_timer.sv
// Saturating up-counter with synchronous clear, load and terminal-count compare.
// One instance is shared by the timeout, debounce and lockout functions.
module auth_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] tc_val,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == tc_val);

endmodule

// File: rtl/auth_seq_ctrl.sv
// Byte-stream power-up authenticator: multi-byte ON key, STOP with rider-off debounce.
// Define AUTH_LOCKOUT_EN to enable the failed-attempt lockout (LOCK state).
module auth_seq_ctrl
  import auth_pkg::*;
#(
  parameter int                   KEY_LEN   = 2,
  parameter logic [KEY_LEN*8-1:0] ON_KEY    = DEF_ON_KEY,
  parameter logic [7:0]           STOP_BYTE = DEF_STOP_BYTE,
  parameter int                   TMO_CYC   = 50000,
  parameter int                   OFF_DBNC  = 1024,
  parameter int                   MAX_FAIL  = 3,
  parameter int                   LOCK_CYC  = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  input  logic       rider_off,
  output logic       clr_rx_rdy,
  output logic       pwr_up,
  output logic       stopping,
  output logic       locked
);

  localparam int IW    = $clog2(KEY_LEN + 1);
  localparam int MAX_A = (TMO_CYC > OFF_DBNC) ? TMO_CYC : OFF_DBNC;
  localparam int MAX_T = (MAX_A > LOCK_CYC) ? MAX_A : LOCK_CYC;
  localparam int TW    = $clog2(MAX_T + 1);

  state_t          state, nxt_base, nxt_state;
  logic [IW-1:0]   idx, idx_next;
  logic [7:0]      key0, key_cur;
  logic            tmr_load, tmr_inc, tmr_tc;
  logic [TW-1:0]   tmr_count, tc_val;

  function automatic logic [7:0] key_byte(input int i);
    return ON_KEY[KEY_LEN*8-1-8*i -: 8];
  endfunction

  assign key0       = key_byte(0);
  assign key_cur    = key_byte(int'(idx));
  assign clr_rx_rdy = rx_rdy & ~rst;

  auth_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .clr      (rst),
    .load     (tmr_load),
    .load_val ('0),
    .inc      (tmr_inc),
    .tc_val   (tc_val),
    .count    (tmr_count),
    .tc       (tmr_tc)
  );

  // Terminal count is "last cycle of the window", so the compare fires on the Nth cycle.
  always_comb begin
    tc_val = '0;
    case (state)
      MATCH:    tc_val = TW'(TMO_CYC - 1);
      STOPPING: tc_val = TW'(OFF_DBNC - 1);
      LOCK:     tc_val = TW'(LOCK_CYC - 1);
      default:  tc_val = '0;
    endcase
  end

  always_comb begin
    nxt_base = state;
    idx_next = idx;
    tmr_load = 1'b0;
    tmr_inc  = 1'b0;
    case (state)
      IDLE: begin
        tmr_load = 1'b1;
        if (rx_rdy && (rx_data == key0)) begin
          nxt_base = (KEY_LEN == 1) ? ON : MATCH;
          idx_next = IW'(1);
        end
      end
      MATCH: begin
        if (rx_rdy) begin
          tmr_load = 1'b1;
          if (rx_data == key_cur) begin
            if (int'(idx) == KEY_LEN - 1) nxt_base = ON;
            else                           idx_next = idx + IW'(1);
          end else if (rx_data == key0) begin
            idx_next = IW'(1);
          end else begin
            nxt_base = IDLE;
          end
        end else if (tmr_tc) begin
          tmr_load = 1'b1;
          nxt_base = IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ON: begin
        tmr_load = 1'b1;
        if (rx_rdy && (rx_data == STOP_BYTE)) nxt_base = STOPPING;
      end
      // A key[0] byte cancels the stop even in the cycle debounce would complete.
      STOPPING: begin
        if (rx_rdy && (rx_data == key0)) begin
          tmr_load = 1'b1;
          nxt_base = ON;
        end else if (!rider_off) begin
          tmr_load = 1'b1;
        end else if (tmr_tc) begin
          tmr_load = 1'b1;
          nxt_base = IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      LOCK: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          nxt_base = IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: nxt_base = IDLE;
    endcase
  end

`ifdef AUTH_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAIL + 1);
  logic [FW-1:0] fail_cnt;
  logic          fail_inc, fail_clr, go_lock;

  assign fail_inc  = (state == MATCH) && (rx_rdy ? (rx_data != key_cur) : tmr_tc);
  assign fail_clr  = ((state == IDLE || state == MATCH) && nxt_base == ON) ||
                     (state == LOCK && nxt_base == IDLE);
  assign go_lock   = fail_inc && (int'(fail_cnt) + 1 >= MAX_FAIL);
  assign nxt_state = go_lock ? LOCK : nxt_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      if (fail_clr)                                 fail_cnt <= '0;
      else if (fail_inc && int'(fail_cnt) < MAX_FAIL) fail_cnt <= fail_cnt + FW'(1);
      locked <= (nxt_state == LOCK);
    end
  end
`else
  assign nxt_state = nxt_base;
  assign locked    = 1'b0;
`endif

  // Outputs are decoded from the next state so they follow the causing event by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      pwr_up   <= 1'b0;
      stopping <= 1'b0;
    end else begin
      state    <= nxt_state;
      idx      <= (nxt_state == MATCH) ? idx_next : '0;
      pwr_up   <= (nxt_state == ON) || (nxt_state == STOPPING);
      stopping <= (nxt_state == STOPPING);
    end
  end

endmodule
